// File: rtl/fsm_sched_pkg.sv
//------------------------------------------------------------------------------
// fsm_sched_pkg : widths, state codes and reset contents of the shared table
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fsm_sched_pkg;

  localparam int ST_W    = 3;
  localparam int OUT_W   = 3;
  localparam int ENTRY_W = ST_W + OUT_W;

  localparam logic [ST_W-1:0] S0 = 3'd0;
  localparam logic [ST_W-1:0] S1 = 3'd1;
  localparam logic [ST_W-1:0] S2 = 3'd2;
  localparam logic [ST_W-1:0] S3 = 3'd3;
  localparam logic [ST_W-1:0] S4 = 3'd4;

  // Indexed by {state, a}; entry = {next, out}. States 5..7 fall back to s0/out 0.
  localparam logic [ENTRY_W-1:0] DEFAULT_TABLE [0:15] = '{
    6'h0A, 6'h0A, 6'h15, 6'h25, 6'h1E, 6'h1E, 6'h04, 6'h0C,
    6'h13, 6'h13, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00
  };

  function automatic logic [ENTRY_W-1:0] default_entry(input int idx);
    if (idx >= 0 && idx < 16) return DEFAULT_TABLE[idx];
    return '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter : round-robin pick of one requester, pointer advances past winner
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  always_comb begin : comb_pick
    int j;
    w_found = 1'b0;
    w_idx   = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(j);
      end
    end
  end

  assign gnt     = w_found ? (N'(1) << w_idx) : '0;
  assign gnt_idx = w_idx;

  // Pointer only moves when a grant is actually consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fsm_ctx_sched.sv
//------------------------------------------------------------------------------
// fsm_ctx_sched : N contexts time-share one programmable next-state/output table
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fsm_ctx_sched #(
  parameter int N_CTX = 4,
  parameter int ST_W  = fsm_sched_pkg::ST_W,
  parameter int OUT_W = fsm_sched_pkg::OUT_W,
  parameter int CTX_W = (N_CTX > 1) ? $clog2(N_CTX) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CTX-1:0]      req,
  input  logic [N_CTX-1:0]      a_in,
  input  logic [N_CTX-1:0]      ctx_clr,
  input  logic                  cfg_we,
  input  logic [ST_W:0]         cfg_addr,
  input  logic [ST_W+OUT_W-1:0] cfg_data,
  output logic [N_CTX-1:0]      grant,
  output logic                  out_valid,
  output logic [CTX_W-1:0]      out_ctx,
  output logic [OUT_W-1:0]      out_val,
  output logic [ST_W-1:0]       out_state
);
  import fsm_sched_pkg::*;

  localparam int DEPTH   = 2 ** (ST_W + 1);
  localparam int ENT_W   = ST_W + OUT_W;

  logic [ENT_W-1:0] r_table [DEPTH];
  logic [ST_W-1:0]  r_state [N_CTX];

  logic [N_CTX-1:0] w_gnt;
  logic [CTX_W-1:0] w_idx;
  logic             w_step;
  logic [ST_W:0]    w_addr;
  logic [ENT_W-1:0] w_entry;
  logic [ST_W-1:0]  w_next;
  logic [OUT_W-1:0] w_out;

  // Cleared contexts sit out this cycle; a table write suppresses any step.
  rr_arbiter #(.N(N_CTX), .IDX_W(CTX_W)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req & ~ctx_clr),
    .advance (~cfg_we),
    .gnt     (w_gnt),
    .gnt_idx (w_idx)
  );

  assign w_step  = ~cfg_we & (|w_gnt);
  assign w_addr  = {r_state[w_idx], a_in[w_idx]};
  assign w_entry = r_table[w_addr];
  assign w_next  = w_entry[ENT_W-1 -: ST_W];
  assign w_out   = w_entry[OUT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= ENT_W'(default_entry(i));
    end else if (cfg_we) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CTX; i++) r_state[i] <= '0;
    end else begin
      for (int i = 0; i < N_CTX; i++) begin
        if (ctx_clr[i])                r_state[i] <= '0;
        else if (w_step && w_gnt[i])   r_state[i] <= w_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant     <= '0;
      out_valid <= 1'b0;
      out_ctx   <= '0;
      out_val   <= '0;
      out_state <= '0;
    end else begin
      grant     <= w_step ? w_gnt : '0;
      out_valid <= w_step;
      if (w_step) begin
        out_ctx   <= w_idx;
        out_val   <= w_out;
        out_state <= w_next;
      end
    end
  end

endmodule

`default_nettype wire
